rs_latch: RTL and testbench
===========================

# rs_latch

Clocked, parameterizable-width set/reset storage element (RS latch) for small control-state bits: flags, mode bits, sticky status. Each bit is set by S, cleared by R, sampled on the rising edge of the system clock (50 MHz in the standard bench), and held otherwise. Simultaneous set and reset is resolved by a fixed, parameter-selected policy and reported on an error output.

## Interface

Parameters:
- WIDTH, 1: number of independent latch bits; S, R, Q, Qn, Err all WIDTH bits.
- CONFLICT, 2: per-bit policy when S=R=1. 0 = hold, 1 = set wins, 2 = reset wins.
- RESET_VAL, 0: value loaded into Q on reset, WIDTH bits.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  reset, **asynchronous, active-low**; forces Q=RESET_VAL immediately.
- S  input  WIDTH  per-bit set request, active-high.
- R  input  WIDTH  per-bit reset request, active-high.
- Q  output  WIDTH  stored state, registered.
- Qn  output  WIDTH  bitwise complement of Q.
- Err  output  WIDTH  per-bit conflict flag: bit i is 1 for the cycle after S[i]=R[i]=1 was sampled.

## Operation

- Bits are fully independent; bit i depends only on S[i], R[i], Q[i].
- At each rising Clk edge with Reset_n=1, per bit:
  - S=0,R=0: hold Q.
  - S=1,R=0: Q<=1.
  - S=0,R=1: Q<=0.
  - S=1,R=1: resolved by CONFLICT (0 hold, 1 Q<=1, 2 Q<=0); Err<=1.
- Err<=0 on any edge where S[i]&R[i]=0; Err is not sticky.
- Qn is always exactly ~Q, including during reset; no state where Q and Qn agree.
- Reset_n=0: Q=RESET_VAL, Qn=~RESET_VAL, Err=0, asynchronously, regardless of Clk, S, R; held while Reset_n=0.
- Invalid CONFLICT values (3+) are a synthesis-time error.
- S and R are synchronous inputs; the block contains no synchronizers.

## Timing

- Latency: S/R sampled at edge n appear on Q/Err after edge n (one register stage); no combinational path from S/R to any output.
- Reset assertion: outputs take reset values within the same time step as the Reset_n fall, no clock needed.
- Reset release: the first rising edge with Reset_n=1 samples S/R normally. Deassertion must meet recovery/removal to Clk; an edge coincident with release may be ignored.
- Reset mid-operation: pending S/R at the asserting moment are discarded; no S/R edge while Reset_n=0 alters state.
- Repeated S (or R) on consecutive edges: Q stays at 1 (or 0); no toggling.
- Glitches on S/R between edges have no effect.

## Test plan

- Reset: Reset_n=0 at t=0 with S=1, clock running (20 ns period) -> Q=0, Qn=1, Err=0 for every edge until release; after release, with S=1, Q=1 after the next rising edge.
- Set/hold/reset: S=1 one cycle -> Q=1 after that edge; S=R=0 five cycles -> Q stays 1; R=1 one cycle -> Q=0, Qn=1.
- Conflict, default CONFLICT=2: from Q=1 drive S=R=1 one cycle -> Q=0, Err=1 for exactly one cycle, then Err=0. Repeat with CONFLICT=0 (Q stays 1) and CONFLICT=1 (Q=1).
- Async reset mid-operation: Q=1, pull Reset_n low 3 ns after a rising edge -> Q=0 immediately without waiting for Clk; S=1 pulses during reset ignored.
- Width/independence: WIDTH=8, RESET_VAL=8'hA5; after reset Q=8'hA5; drive S=8'h0F, R=8'hF0 -> Q=8'h0F, Qn=8'hF0; then S=8'h01, R=8'h01 -> Q=8'h0E, Err=8'h01.
- Between-edge glitch: 2 ns S pulse fully between rising edges -> Q unchanged.

Source files
------------

// File: rtl/rs_latch.sv
// Clocked set/reset storage for control flags, one independent bit per lane.
// Simultaneous set and reset follows the CONFLICT policy and raises Err for one cycle.
module rs_latch #(
  parameter int                WIDTH     = 1,
  parameter int                CONFLICT  = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] Err
);

  generate
    if (CONFLICT < 0 || CONFLICT > 2) begin : g_bad_conflict
      $error("rs_latch: CONFLICT must be 0 (hold), 1 (set wins) or 2 (reset wins)");
    end
  endgenerate

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] err_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] err_next;

  always_comb begin
    q_next   = q_reg;
    err_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case ({S[i], R[i]})
        2'b10: q_next[i] = 1'b1;
        2'b01: q_next[i] = 1'b0;
        2'b11: begin
          err_next[i] = 1'b1;
          if (CONFLICT == 1)
            q_next[i] = 1'b1;
          else if (CONFLICT == 2)
            q_next[i] = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q_reg   <= RESET_VAL;
      err_reg <= '0;
    end else begin
      q_reg   <= q_next;
      err_reg <= err_next;
    end
  end

  // Qn derives from the same register so it can never agree with Q.
  assign Q   = q_reg;
  assign Qn  = ~q_reg;
  assign Err = err_reg;

endmodule

// File: tb/tb_rs_latch.sv
// Scoreboard bench: four latch configurations share clock and reset; expected
// responses are queued by the stimulus and checked by an independent monitor.
module tb_rs_latch;

  logic       Clk;
  logic       Reset_n;
  logic       s_a, r_a;
  logic [7:0] s_w, r_w;

  logic       q_def, qn_def, err_def;
  logic       q_c0, qn_c0, err_c0;
  logic       q_c1, qn_c1, err_c1;
  logic [7:0] q_w, qn_w, err_w;

  rs_latch u_def (
    .Clk(Clk), .Reset_n(Reset_n), .S(s_a), .R(r_a),
    .Q(q_def), .Qn(qn_def), .Err(err_def)
  );

  rs_latch #(.CONFLICT(0)) u_c0 (
    .Clk(Clk), .Reset_n(Reset_n), .S(s_a), .R(r_a),
    .Q(q_c0), .Qn(qn_c0), .Err(err_c0)
  );

  rs_latch #(.CONFLICT(1)) u_c1 (
    .Clk(Clk), .Reset_n(Reset_n), .S(s_a), .R(r_a),
    .Q(q_c1), .Qn(qn_c1), .Err(err_c1)
  );

  rs_latch #(.WIDTH(8), .CONFLICT(2), .RESET_VAL(8'hA5)) u_w8 (
    .Clk(Clk), .Reset_n(Reset_n), .S(s_w), .R(r_w),
    .Q(q_w), .Qn(qn_w), .Err(err_w)
  );

  typedef struct {
    time        due;
    string      lbl;
    logic       qd, qc0, qc1, e1;
    logic [7:0] qw, ew;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  task automatic chk(input string lbl, input string field,
                     input logic [7:0] act, input logic [7:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h at %0t", lbl, field, act, exp_v, $time);
    end
  endtask

  task automatic push_exp(input time due, input string lbl,
                          input logic qd, qc0, qc1, e1,
                          input logic [7:0] qw, ew);
    exp_t e;
    e.due = due; e.lbl = lbl;
    e.qd = qd; e.qc0 = qc0; e.qc1 = qc1; e.e1 = e1;
    e.qw = qw; e.ew = ew;
    sb.push_back(e);
  endtask

  // Monitor: outputs are presented on every clock edge and on reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk or negedge Reset_n);
      #1;
      while (sb.size() != 0 && sb[0].due <= $time) begin
        e = sb.pop_front();
        if (e.due != $time) begin
          total++;
          bad++;
          $display("FAIL %s.timing: checked at %0t expected at %0t", e.lbl, $time, e.due);
        end
        chk(e.lbl, "q_def",   {7'b0, q_def},   {7'b0, e.qd});
        chk(e.lbl, "qn_def",  {7'b0, qn_def},  {7'b0, ~e.qd});
        chk(e.lbl, "err_def", {7'b0, err_def}, {7'b0, e.e1});
        chk(e.lbl, "q_c0",    {7'b0, q_c0},    {7'b0, e.qc0});
        chk(e.lbl, "qn_c0",   {7'b0, qn_c0},   {7'b0, ~e.qc0});
        chk(e.lbl, "err_c0",  {7'b0, err_c0},  {7'b0, e.e1});
        chk(e.lbl, "q_c1",    {7'b0, q_c1},    {7'b0, e.qc1});
        chk(e.lbl, "qn_c1",   {7'b0, qn_c1},   {7'b0, ~e.qc1});
        chk(e.lbl, "err_c1",  {7'b0, err_c1},  {7'b0, e.e1});
        chk(e.lbl, "q_w",     q_w,             e.qw);
        chk(e.lbl, "qn_w",    qn_w,            ~e.qw);
        chk(e.lbl, "err_w",   err_w,           e.ew);
      end
    end
  end

  // Drive inputs at a falling edge; expectation applies after the next rising edge.
  task automatic step(input string lbl, input logic rel,
                      input logic sa, ra, input logic [7:0] sw, rw,
                      input logic qd, qc0, qc1, e1,
                      input logic [7:0] qw, ew);
    @(negedge Clk);
    if (rel) Reset_n = 1'b1;
    s_a = sa; r_a = ra; s_w = sw; r_w = rw;
    push_exp($time + 11, lbl, qd, qc0, qc1, e1, qw, ew);
  endtask

  initial begin
    Reset_n = 1'b0;
    s_a = 1'b1; r_a = 1'b0; s_w = 8'hFF; r_w = 8'h00;

    repeat (3) step("rst_hold", 0, 1, 0, 8'hFF, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h00);

    step("rel_set",   1, 1, 0, 8'h0F, 8'hF0, 1, 1, 1, 0, 8'h0F, 8'h00);
    repeat (5) step("hold", 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h0F, 8'h00);
    step("reset_bit", 0, 0, 1, 8'h01, 8'h01, 0, 0, 0, 0, 8'h0E, 8'h01);
    step("set_again", 0, 1, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h0E, 8'h00);
    step("conflict",  0, 1, 1, 8'hF0, 8'h00, 0, 1, 1, 1, 8'hFE, 8'h00);
    step("err_clear", 0, 0, 0, 8'h00, 8'hFF, 0, 1, 1, 0, 8'h00, 8'h00);
    repeat (2) step("rep_set",   0, 1, 0, 8'h80, 8'h00, 1, 1, 1, 0, 8'h80, 8'h00);
    repeat (2) step("rep_reset", 0, 0, 1, 8'hFF, 8'hFF, 0, 0, 0, 0, 8'h00, 8'hFF);
    step("set_pre_rst", 0, 1, 0, 8'h3C, 8'h00, 1, 1, 1, 0, 8'h3C, 8'h00);

    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    push_exp($time + 1, "async_rst", 0, 0, 0, 0, 8'hA5, 8'h00);

    repeat (2) step("rst_pulse", 0, 1, 0, 8'hFF, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h00);
    step("post_rel_hold", 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h00);

    @(negedge Clk);
    s_a = 1'b0; r_a = 1'b0; s_w = 8'h00; r_w = 8'h00;
    push_exp($time + 11, "glitch", 0, 0, 0, 0, 8'hA5, 8'h00);
    #2;
    s_a = 1'b1; s_w = 8'hFF;
    #2;
    s_a = 1'b0; s_w = 8'h00;

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge Clk);
    #5;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
